usb_input: RTL and testbench
============================

USB_INPUT -- requirements
Module: usb_input

Interface
REQ-001 Parameter DATA_W, default 24: width of one assembled pixel word.
REQ-002 Parameter FIFO_DEPTH, default 2: number of assembled words buffered toward the consumer.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 usb_data_in  input  1  serial data bit from the USB link, MSB of the word first.
REQ-006 usb_bit_valid  input  1  usb_data_in carries a bit this cycle.
REQ-007 usb_sof  input  1  start-of-word resync strobe from the link.
REQ-008 usb_ready  output  1  registered; block accepts a bit this cycle.
REQ-009 data_out  output  DATA_W  head word of the output FIFO.
REQ-010 data_valid  output  1  data_out holds a valid word (FIFO not empty).
REQ-011 data_ready  input  1  consumer accepts data_out this cycle.
REQ-012 overrun  output  1  sticky error: a bit was offered while usb_ready was 0.

Function
REQ-013 A bit SHALL be accepted only on an edge where usb_bit_valid=1 and usb_ready=1; the shift register becomes {sr[DATA_W-2:0], usb_data_in} and the bit counter increments.
REQ-014 The FSM SHALL have three states: IDLE (count=0), SHIFT (count 1..DATA_W-1), STALL (DATA_W bits held, FIFO full).
REQ-015 IDLE->SHIFT on an accepted bit; SHIFT stays SHIFT while count < DATA_W-1 after the accept.
REQ-016 On acceptance of bit DATA_W with the FIFO not full (or being popped the same edge), the assembled word SHALL be written into the FIFO on that edge and the FSM SHALL return to IDLE; data_valid rises the following cycle (1-cycle latency from last bit).
REQ-017 On acceptance of bit DATA_W with the FIFO full and no pop that edge, the FSM SHALL enter STALL holding the word; usb_ready SHALL be 0 from the next cycle.
REQ-018 In STALL, on the first edge with data_valid=1 and data_ready=1, the held word SHALL be pushed, the FSM SHALL return to IDLE and usb_ready SHALL be 1 from the next cycle.
REQ-019 usb_ready SHALL equal 0 exactly when the FSM is (or will next be) in STALL, computed from next-state and registered.
REQ-020 usb_sof in IDLE or SHIFT SHALL discard any partial word; with usb_bit_valid=1 that same bit becomes bit DATA_W-1 of the new word (count=1), otherwise count=0 and state IDLE.
REQ-021 usb_sof in STALL SHALL be ignored; the held word is kept.
REQ-022 usb_bit_valid=1 while usb_ready=0 SHALL set overrun to 1 and drop the bit; overrun clears only on reset.
REQ-023 The FIFO SHALL pop on data_valid=1 and data_ready=1, support simultaneous push and pop when full, and present words in arrival order.
REQ-024 data_out SHALL hold its value while data_valid=1 and data_ready=0.

Reset
REQ-025 While rst_n=0 at an edge: state IDLE, count 0, shift register 0, FIFO empty, data_valid 0, data_out 0, overrun 0, usb_ready 0.
REQ-026 usb_ready SHALL rise on the first edge after rst_n returns to 1.
REQ-027 Reset mid-word or in STALL SHALL discard all partial, held and buffered words.

Structure
REQ-028 Package usb_pkg SHALL hold DATA_W and FIFO_DEPTH defaults and the FSM state enumeration, shared with USBOutput.
REQ-029 The output buffer SHALL be a sub-module usb_rx_fifo (parameterised width/depth, push/pop, full/empty).

Verification
REQ-030 Serialise 24'hAABBCC, one bit per cycle, data_ready=1 -> data_out=24'hAABBCC, data_valid=1 one cycle after bit 24, overrun=0.
REQ-031 Words 24'hAABBCC, 24'h112233, 24'h445566 back-to-back, data_ready=0 -> FIFO holds first two, STALL after third, usb_ready=0; raise data_ready -> outputs AABBCC, 112233, 445566 in order, usb_ready returns 1.
REQ-032 In STALL, drive usb_bit_valid=1 -> overrun=1 and stays 1 after the stall clears; bit not included in any word.
REQ-033 Send 10 bits, then usb_sof with bit, then 23 further bits of 24'h112233 -> single word 24'h112233, no word from the partial.
REQ-034 rst_n=0 after 12 bits of a word with one word buffered -> data_valid=0, overrun=0, usb_ready=0 during reset, 1 one cycle after release; next full word 24'hAABBCC received intact.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared word/FIFO defaults and FSM state encoding for the USB deserialiser path
package usb_pkg;

  localparam int USB_DATA_W     = 24;
  localparam int USB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STALL = 2'd2
  } usb_state_e;

endpackage

// File: rtl/usb_rx_fifo.sv
// rtl/usb_rx_fifo.sv - small synchronous FIFO for assembled words, push and pop allowed together when full
module usb_rx_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Explicit wrap so non power-of-two depths still cycle correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usb_input.sv
// rtl/usb_input.sv - serial-to-parallel pixel word assembler with stall, resync and overrun detection
module usb_input
  import usb_pkg::*;
#(
  parameter int DATA_W     = USB_DATA_W,
  parameter int FIFO_DEPTH = USB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              usb_data_in,
  input  logic              usb_bit_valid,
  input  logic              usb_sof,
  output logic              usb_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  usb_state_e        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_shift;
  logic [DATA_W-1:0] push_data;
  logic              accept;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              can_push;
  logic              last_bit;

  assign accept     = usb_bit_valid & usb_ready;
  assign data_valid = ~fifo_empty;
  assign pop        = data_valid & data_ready;
  assign can_push   = ~fifo_full | pop;
  assign sr_shift   = {sr[DATA_W-2:0], usb_data_in};
  assign last_bit   = accept & ~usb_sof & (state != ST_STALL) & (count == CNT_W'(DATA_W - 1));

  // A word enters the FIFO either straight off its final bit or from the STALL holding register.
  assign push      = (last_bit & can_push) | ((state == ST_STALL) & pop);
  assign push_data = (state == ST_STALL) ? sr : sr_shift;

  usb_rx_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      sr        <= '0;
      usb_ready <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (usb_bit_valid && !usb_ready) overrun <= 1'b1;
      case (state)
        ST_IDLE, ST_SHIFT: begin
          usb_ready <= 1'b1;
          if (usb_sof) begin
            // Resync: the strobing bit, if taken, is the MSB of a fresh word.
            if (accept) begin
              sr    <= DATA_W'(usb_data_in);
              count <= CNT_W'(1);
              state <= ST_SHIFT;
            end else begin
              sr    <= '0;
              count <= '0;
              state <= ST_IDLE;
            end
          end else if (accept) begin
            sr <= sr_shift;
            if (count == CNT_W'(DATA_W - 1)) begin
              if (can_push) begin
                count <= '0;
                state <= ST_IDLE;
              end else begin
                count     <= CNT_W'(DATA_W);
                state     <= ST_STALL;
                usb_ready <= 1'b0;
              end
            end else begin
              count <= count + 1'b1;
              state <= ST_SHIFT;
            end
          end
        end
        ST_STALL: begin
          if (pop) begin
            count     <= '0;
            state     <= ST_IDLE;
            usb_ready <= 1'b1;
          end else begin
            usb_ready <= 1'b0;
          end
        end
        default: begin
          count     <= '0;
          state     <= ST_IDLE;
          usb_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_input.sv
// tb/tb_usb_input.sv - randomized and directed bench for usb_input against a word-queue reference model
module tb_usb_input;

  localparam int DW    = 24;
  localparam int DEPTH = 2;
  localparam logic [31:0] MASK = 32'h00FF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          usb_data_in = 1'b0;
  logic          usb_bit_valid = 1'b0;
  logic          usb_sof = 1'b0;
  logic          usb_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready = 1'b0;
  logic          overrun;

  int checks = 0;
  int failures = 0;

  // Model: completed words awaiting the consumer; anything beyond DEPTH is the stalled word.
  logic [31:0] q[$];
  logic [31:0] m_word = 0;
  int          m_nbits = 0;
  bit          m_rdy = 0;
  bit          m_ovr = 0;

  usb_input #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .usb_data_in   (usb_data_in),
    .usb_bit_valid (usb_bit_valid),
    .usb_sof       (usb_sof),
    .usb_ready     (usb_ready),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rn, input bit bv, input bit b, input bit sof, input bit dr);
    bit acc, pop, held, done;
    if (!rn) begin
      q.delete();
      m_word = 0; m_nbits = 0; m_rdy = 0; m_ovr = 0;
      return;
    end
    acc  = bv && m_rdy;
    pop  = (q.size() > 0) && dr;
    held = q.size() > DEPTH;
    done = 0;
    if (bv && !m_rdy) m_ovr = 1;
    if (!held) begin
      if (sof) begin
        m_nbits = acc ? 1 : 0;
        m_word  = acc ? 32'(b) : 0;
      end else if (acc) begin
        m_word = ((m_word << 1) | 32'(b)) & MASK;
        m_nbits++;
        if (m_nbits == DW) done = 1;
      end
    end
    if (pop) void'(q.pop_front());
    if (done) begin
      q.push_back(m_word);
      m_word = 0; m_nbits = 0;
    end
    m_rdy = (q.size() <= DEPTH);
  endtask

  task automatic step(input bit rn, input bit bv, input bit b, input bit sof, input bit dr);
    rst_n = rn; usb_bit_valid = bv; usb_data_in = b; usb_sof = sof; data_ready = dr;
    @(posedge clk);
    model_edge(rn, bv, b, sof, dr);
    #1;
    check("usb_ready", 32'(usb_ready), 32'(m_rdy));
    check("data_valid", 32'(data_valid), 32'(q.size() > 0));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (q.size() > 0)  check("data_out", 32'(data_out), q[0]);
    else if (!rn)      check("data_out_rst", 32'(data_out), 32'h0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit dr);
    for (int i = DW - 1; i >= 0; i--) step(1, 1, w[i], 0, dr);
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, dr);
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Single word, consumer always ready
    send_word(32'hAABBCC, 1);
    check("single_word_visible", 32'(data_out), 32'hAABBCC);
    idle(3, 1);

    // Three back-to-back words with consumer blocked, then drain
    send_word(32'hAABBCC, 0);
    send_word(32'h112233, 0);
    send_word(32'h445566, 0);
    check("stall_ready_low", 32'(usb_ready), 32'h0);
    idle(2, 0);
    check("stall_head", 32'(data_out), 32'hAABBCC);
    idle(6, 1);

    // Bit offered during stall
    send_word(32'h123456, 0);
    send_word(32'h654321, 0);
    send_word(32'h0F0F0F, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 0);
    check("overrun_set", 32'(overrun), 32'h1);
    idle(6, 1);
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Partial word discarded by resync
    for (int i = 0; i < 10; i++) step(1, 1, 1'($urandom), 0, 1);
    w = 32'h112233;
    step(1, 1, w[23], 1, 1);
    for (int i = 22; i >= 0; i--) step(1, 1, w[i], 0, 1);
    check("resync_word", 32'(data_out), 32'h112233);
    idle(3, 1);

    // Reset mid-word with one word buffered
    send_word(32'h777777, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 1'($urandom), 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("ready_after_release", 32'(usb_ready), 32'h1);
    send_word(32'hAABBCC, 0);
    check("post_reset_word", 32'(data_out), 32'hAABBCC);
    idle(2, 1);

    // Random traffic with bursts of back-pressure and one reset
    for (int i = 0; i < 3000; i++) begin
      bit dr;
      dr = ((i / 150) % 2 == 1) ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      step((i != 1500), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 39) == 0), dr);
    end
    idle(20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
